// File: rtl/myproject_dense_pkg.sv
// Shared types, default widths and the saturation helper for the dense-layer accumulator.
package myproject_dense_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int unsigned DEF_PROD_WIDTH = 23;
    localparam int unsigned DEF_ACC_WIDTH  = 28;
    localparam int unsigned DEF_N_IN       = 16;
    localparam int unsigned DEF_FRAC_SHIFT = 6;
    localparam int unsigned DEF_OUT_WIDTH  = 16;
    localparam int unsigned DEF_RELU       = 1;

    // Clamp a sign-extended value to the signed range of a w-bit result; caller truncates.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/myproject_dense_requant.sv
// Combinational requantiser: floor shift, optional ReLU, saturate to OUT_WIDTH.
module myproject_dense_requant
    import myproject_dense_pkg::*;
#(
    parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int unsigned FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int unsigned RELU       = DEF_RELU
) (
    input  logic signed [ACC_WIDTH-1:0] sum,
    output logic signed [OUT_WIDTH-1:0] result
);

    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [ACC_WIDTH-1:0] rectified;

    always_comb begin
        shifted   = sum >>> FRAC_SHIFT;
        rectified = ((RELU != 0) && shifted[ACC_WIDTH-1]) ? '0 : shifted;
        result    = OUT_WIDTH'(sat_signed(64'(rectified), OUT_WIDTH));
    end

endmodule

// File: rtl/myproject_dense_acc.sv
// Dense-layer neuron accumulator: bias + N_IN products, requantised onto a valid/ready output.
module myproject_dense_acc
    import myproject_dense_pkg::*;
#(
    parameter int unsigned PROD_WIDTH = DEF_PROD_WIDTH,
    parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int unsigned N_IN       = DEF_N_IN,
    parameter int unsigned FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int unsigned RELU       = DEF_RELU
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [PROD_WIDTH-1:0] in_data,
    input  logic                         in_last,
    input  logic signed [ACC_WIDTH-1:0]  bias,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         err
);

    localparam int unsigned CNT_W = $clog2(N_IN);

    state_t                      state;
    logic [CNT_W-1:0]            cnt;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH-1:0] sum_next;
    logic signed [OUT_WIDTH-1:0] requant;
    logic                        last_term;
    logic                        accept;
    logic                        load;

    // Only the closing term stalls: earlier terms of the next vector may pile onto acc.
    always_comb begin
        last_term = (cnt == CNT_W'(N_IN - 1));
        in_ready  = ce & ~(last_term & out_valid & ~out_ready);
        accept    = ce & in_valid & in_ready;
        load      = accept & last_term;
        base      = (state == IDLE) ? bias : acc;
        sum_next  = base + ACC_WIDTH'(in_data);
    end

    myproject_dense_requant #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .FRAC_SHIFT(FRAC_SHIFT),
        .RELU      (RELU)
    ) u_requant (
        .sum   (sum_next),
        .result(requant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else if (ce) begin
            if (accept) begin
                acc <= sum_next;
                if (last_term) begin
                    cnt   <= '0;
                    state <= IDLE;
                end else begin
                    cnt   <= cnt + CNT_W'(1);
                    state <= ACCUM;
                end
                if (in_last != last_term)
                    err <= 1'b1;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= requant;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_myproject_dense_acc.sv
// Bench for myproject_dense_acc: ReLU and non-ReLU instances share stimulus and a result scoreboard.
module tb_myproject_dense_acc;

    logic               clk = 1'b0;
    logic               reset;
    logic               ce;
    logic               in_valid;
    logic               in_last;
    logic               out_ready;
    logic signed [22:0] in_data;
    logic signed [27:0] bias;
    logic               in_ready1, in_ready0;
    logic               out_valid1, out_valid0;
    logic               err1, err0;
    logic signed [15:0] out_data1, out_data0;

    always #5 clk = ~clk;

    myproject_dense_acc dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_last(in_last), .bias(bias), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .err(err1)
    );

    myproject_dense_acc #(.RELU(0)) dut_nr (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_last(in_last), .bias(bias), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .err(err0)
    );

    typedef struct {
        int bias;
        int prod;
        int exp1;
        int exp0;
    } vec_t;

    typedef struct {
        int e1;
        int e0;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int model(input longint s, input bit relu);
        longint r;
        r = s >>> 6;
        if (relu && r < 0) r = 0;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic push(input int e1, input int e0);
        exp_t e;
        e.e1 = e1;
        e.e0 = e0;
        sb.push_back(e);
    endtask

    // Present one term and hold it until accepted; returns the number of stalled cycles.
    task automatic send_term(input int d, input bit last, input int b, output int stalls);
        in_valid = 1'b1;
        in_data  = 23'(d);
        in_last  = last;
        bias     = 28'(b);
        stalls   = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready1) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            stalls++;
        end
        checks++;
        failures++;
        $display("FAIL send_timeout actual=stalled required=accept data=%0d", d);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Scoreboard monitor: a result is consumed on any cycle where the handshake completes.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && ce && out_valid1 && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual=%0d required=no_output", out_data1);
                end else begin
                    e = sb.pop_front();
                    chk("relu_data", out_data1, e.e1);
                    chk("norelu_data", out_data0, e.e0);
                    chk("norelu_valid", out_valid0, 1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        int   st;
        int   stall_sum;
        int   b;
        int   d;
        longint s;

        tbl[0]  = '{bias: 0,        prod: 64,       exp1: 16,    exp0: 16};
        tbl[1]  = '{bias: 0,        prod: -100,     exp1: 0,     exp0: -25};
        tbl[2]  = '{bias: -65,      prod: 0,        exp1: 0,     exp0: -2};
        tbl[3]  = '{bias: 0,        prod: 4194303,  exp1: 32767, exp0: 32767};
        tbl[4]  = '{bias: 0,        prod: -4194304, exp1: 0,     exp0: -32768};
        tbl[5]  = '{bias: 1000,     prod: 7,        exp1: 17,    exp0: 17};
        tbl[6]  = '{bias: 6400,     prod: -1,       exp1: 99,    exp0: 99};
        tbl[7]  = '{bias: 2097088,  prod: 0,        exp1: 32767, exp0: 32767};
        tbl[8]  = '{bias: 2097152,  prod: 0,        exp1: 32767, exp0: 32767};
        tbl[9]  = '{bias: -2097152, prod: 0,        exp1: 0,     exp0: -32768};
        tbl[10] = '{bias: -2097216, prod: 0,        exp1: 0,     exp0: -32768};

        reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1; in_data = '0; bias = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid1, 0);
        chk("rst_out_data", out_data1, 0);
        chk("rst_err", err1, 0);
        chk("rst_in_ready", in_ready1, 1);
        reset = 1'b0;

        foreach (tbl[v]) begin
            for (int i = 0; i < 16; i++) begin
                if (i == 15) push(tbl[v].exp1, tbl[v].exp0);
                send_term(tbl[v].prod, i == 15, tbl[v].bias, st);
            end
            chk("tbl_latency_valid", out_valid1, 1);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("tbl_err_clear", err1, 0);

        // Backpressure: two vectors with the output blocked.
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) push(16, 16);
            send_term(64, i == 15, 0, st);
        end
        stall_sum = 0;
        for (int i = 0; i < 15; i++) begin
            send_term(128, 1'b0, 0, st);
            stall_sum += st;
        end
        chk("bp_no_early_stall", stall_sum, 0);
        push(32, 32);
        in_valid = 1'b1; in_data = 23'(128); in_last = 1'b1; bias = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready_low", in_ready1, 0);
        end
        chk("bp_held_valid", out_valid1, 1);
        chk("bp_held_data", out_data1, 16);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_high", in_ready1, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        chk("bp_valid_stays", out_valid1, 1);
        chk("bp_new_data", out_data1, 32);
        repeat (3) @(posedge clk);
        #1;

        // Framing: early in_last raises the sticky error but the vector completes by count.
        for (int i = 0; i < 16; i++) begin
            if (i == 15) push(16, 16);
            send_term(64, i == 9, 0, st);
            if (i == 9) chk("frame_err_set", err1, 1);
        end
        chk("frame_valid", out_valid1, 1);
        chk("frame_err_sticky", err1, 1);
        chk("frame_err_nr", err0, 1);
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-vector at cnt=7, then a clean vector must carry no residue.
        for (int i = 0; i < 7; i++) send_term(64, 1'b0, 0, st);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", out_valid1, 0);
        chk("midrst_err", err1, 0);
        chk("midrst_err_nr", err0, 0);
        chk("midrst_in_ready", in_ready1, 1);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) push(2, 2);
            send_term(10, i == 15, 0, st);
            if (i == 14) chk("clean_not_yet_valid", out_valid1, 0);
        end
        chk("clean_latency_valid", out_valid1, 1);
        repeat (3) @(posedge clk);
        #1;

        // ce low mid-vector, then ce low with a result waiting.
        for (int i = 0; i < 5; i++) send_term((i + 1) * 1000, 1'b0, 500, st);
        in_valid = 1'b1; in_data = 23'(6000); in_last = 1'b0; ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ce_in_ready_low", in_ready1, 0);
        end
        @(posedge clk);
        #1;
        ce = 1'b1;
        for (int i = 5; i < 16; i++) begin
            if (i == 15) push(2132, 2132);
            send_term((i + 1) * 1000, i == 15, 500, st);
        end
        ce = 1'b0;
        repeat (3) @(negedge clk);
        chk("ce_hold_valid", out_valid1, 1);
        chk("ce_hold_data", out_data1, 2132);
        @(posedge clk);
        #1;
        ce = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Random vectors against the reference model, with output readiness toggling.
        for (int v = 0; v < 4; v++) begin
            b = int'($urandom_range(2000000)) - 1000000;
            s = longint'(b);
            for (int i = 0; i < 16; i++) begin
                d = int'($urandom_range(8388607)) - 4194304;
                s += longint'(d);
                if (i == 15) begin
                    out_ready = 1'b1;
                    push(model(s, 1'b1), model(s, 1'b0));
                end else begin
                    out_ready = 1'($urandom_range(1));
                end
                send_term(d, i == 15, b, st);
            end
        end
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
